// File: rtl/codec_config_seq_if.sv
// Handshake bundle between the codec configuration sequencer, the i2c_write
// engine (write/done/register/data) and the top level (start, volume, status).
interface codec_config_seq_if;
    logic       start;
    logic       done;
    logic       write;
    logic [7:0] register;
    logic [7:0] data;
    logic       vol_req;
    logic [6:0] vol_level;
    logic       vol_ack;
    logic       busy;
    logic       ready;
    logic       error;
    logic [2:0] step;

    modport master (
        input  start, done, vol_req, vol_level,
        output write, register, data, vol_ack, busy, ready, error, step
    );

    modport slave (
        output start, done, vol_req, vol_level,
        input  write, register, data, vol_ack, busy, ready, error, step
    );
endinterface

// File: rtl/codec_config_seq.sv
// WM8731 configuration sequencer: walks a fixed 7-entry register table over the
// i2c_write engine, then serves runtime headphone-volume writes on the same engine.
module codec_config_seq #(
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned GAP_CYCLES     = 500,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                sys_clk,
    input  logic                rst,
    codec_config_seq_if.master  bus
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int unsigned CNT_W = (TMO_W > GAP_W) ? TMO_W : GAP_W;
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       LAST_STEP = 3'd6;
    localparam logic [7:0]       VOL_REG   = 8'h05;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REQ, S_REL, S_GAP, S_READY, S_ERR
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       step_q, step_nx;
    logic             item_vol_q, item_vol_nx;
    logic [6:0]       item_lvl_q, item_lvl_nx;
    logic             pend_q;
    logic [6:0]       pend_lvl_q;
    logic             take_pend;
    logic             auto_q;
    logic             tmo, gap_end, counting;

    logic       write_q, write_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] data_q, data_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic       error_q, error_d;
    logic [2:0] step_out_q, step_out_d;

    function automatic logic [15:0] table_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    table_entry = 16'h1E00;
            3'd1:    table_entry = 16'h0812;
            3'd2:    table_entry = 16'h0A00;
            3'd3:    table_entry = 16'h0C00;
            3'd4:    table_entry = 16'h0E02;
            3'd5:    table_entry = 16'h1000;
            default: table_entry = 16'h1201;
        endcase
    endfunction

    assign tmo      = (cnt == TMO_LAST);
    assign gap_end  = (cnt == GAP_LAST);
    assign counting = (state == S_LOAD) || (state == S_REQ) ||
                      (state == S_REL)  || (state == S_GAP);

    // State register plus every registered datapath/output value
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            step_q     <= '0;
            item_vol_q <= 1'b0;
            item_lvl_q <= '0;
            pend_q     <= 1'b0;
            pend_lvl_q <= '0;
            auto_q     <= AUTO_START;
            write_q    <= 1'b0;
            reg_q      <= '0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            step_out_q <= '0;
        end else begin
            state      <= state_nx;
            step_q     <= step_nx;
            item_vol_q <= item_vol_nx;
            item_lvl_q <= item_lvl_nx;
            auto_q     <= 1'b0;
            if (state_nx != state || !counting) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // A new request in the same cycle READY takes the old one keeps it pending
            if (bus.vol_req) begin
                pend_q     <= 1'b1;
                pend_lvl_q <= bus.vol_level;
            end else if (take_pend) begin
                pend_q <= 1'b0;
            end
            write_q    <= write_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            step_out_q <= step_out_d;
        end
    end

    always_comb begin
        state_nx    = state;
        step_nx     = step_q;
        item_vol_nx = item_vol_q;
        item_lvl_nx = item_lvl_q;
        take_pend   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start || auto_q) begin
                    state_nx    = S_LOAD;
                    step_nx     = '0;
                    item_vol_nx = 1'b0;
                end
            end
            S_LOAD: begin
                if (!bus.done)  state_nx = S_REQ;
                else if (tmo)   state_nx = S_ERR;
            end
            S_REQ: begin
                if (bus.done)   state_nx = S_REL;
                else if (tmo)   state_nx = S_ERR;
            end
            S_REL: begin
                if (!bus.done)  state_nx = S_GAP;
                else if (tmo)   state_nx = S_ERR;
            end
            S_GAP: begin
                if (gap_end) begin
                    if (item_vol_q || step_q == LAST_STEP) begin
                        state_nx = S_READY;
                    end else begin
                        state_nx = S_LOAD;
                        step_nx  = step_q + 3'd1;
                    end
                end
            end
            S_READY: begin
                if (bus.start) begin
                    state_nx    = S_LOAD;
                    step_nx     = '0;
                    item_vol_nx = 1'b0;
                end else if (pend_q) begin
                    state_nx    = S_LOAD;
                    step_nx     = '0;
                    item_vol_nx = 1'b1;
                    item_lvl_nx = pend_lvl_q;
                    take_pend   = 1'b1;
                end
            end
            S_ERR: begin
                if (bus.start) begin
                    state_nx    = S_LOAD;
                    step_nx     = '0;
                    item_vol_nx = 1'b0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        logic [15:0] item;
        item       = item_vol_nx ? {VOL_REG, 1'b0, item_lvl_nx} : table_entry(step_nx);
        write_d    = (state_nx == S_REQ);
        busy_d     = (state_nx == S_LOAD) || (state_nx == S_REQ) ||
                     (state_nx == S_REL)  || (state_nx == S_GAP);
        ready_d    = (state_nx == S_READY);
        error_d    = (state_nx == S_ERR);
        ack_d      = (state == S_GAP) && (state_nx == S_READY) && item_vol_q;
        step_out_d = (busy_d && !item_vol_nx) ? step_nx : '0;
        reg_d      = reg_q;
        data_d     = data_q;
        if (state_nx == S_LOAD && state != S_LOAD) begin
            reg_d  = item[15:8];
            data_d = item[7:0];
        end
    end

    assign bus.write    = write_q;
    assign bus.register = reg_q;
    assign bus.data     = data_q;
    assign bus.vol_ack  = ack_q;
    assign bus.busy     = busy_q;
    assign bus.ready    = ready_q;
    assign bus.error    = error_q;
    assign bus.step     = step_out_q;

endmodule

// File: tb/tb_codec_config_seq.sv
// Randomized scoreboard bench for codec_config_seq: expected I2C transactions are
// queued as stimulus is issued and a monitor checks each write rise against them.
module tb_codec_config_seq;

    logic sys_clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 sys_clk = ~sys_clk;

    codec_config_seq_if a_if();
    codec_config_seq_if b_if();

    codec_config_seq #(.AUTO_START(1'b1), .GAP_CYCLES(4), .TIMEOUT_CYCLES(100)) dut_a (
        .sys_clk(sys_clk), .rst(rst_a), .bus(a_if)
    );
    codec_config_seq #(.AUTO_START(1'b0), .GAP_CYCLES(4), .TIMEOUT_CYCLES(100)) dut_b (
        .sys_clk(sys_clk), .rst(rst_b), .bus(b_if)
    );

    localparam logic [15:0] TBL [7] = '{16'h1E00, 16'h0812, 16'h0A00, 16'h0C00,
                                        16'h0E02, 16'h1000, 16'h1201};

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    bit tail_vol = 1'b0;
    int ack_exp = 0;
    int ack_seen = 0;
    bit stall = 1'b0;
    bit hold_hi = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_table();
        for (int i = 0; i < 7; i++) exp_q.push_back(TBL[i]);
        tail_vol = 1'b0;
    endfunction

    // Latest request wins while the queued volume write is still unserved
    function automatic void model_vol(input logic [6:0] v);
        if (tail_vol) begin
            exp_q[exp_q.size()-1] = {8'h05, 1'b0, v};
        end else begin
            exp_q.push_back({8'h05, 1'b0, v});
            tail_vol = 1'b1;
            ack_exp++;
        end
    endfunction

    // done responder: rises 40 cycles into a write, falls 5 cycles after write drops
    int wcnt = 0;
    int lcnt = 0;
    always @(posedge sys_clk) begin
        #2;
        if (hold_hi) begin
            a_if.done = 1'b1; wcnt = 0; lcnt = 0;
        end else if (rst_a || stall) begin
            a_if.done = 1'b0; wcnt = 0; lcnt = 0;
        end else if (a_if.write) begin
            wcnt++; lcnt = 0;
            if (wcnt >= 40) a_if.done = 1'b1;
        end else begin
            wcnt = 0;
            if (a_if.done) begin
                lcnt++;
                if (lcnt >= 5) begin a_if.done = 1'b0; lcnt = 0; end
            end
        end
    end

    logic wr_prev = 1'b0;
    logic ack_prev = 1'b0;
    logic [15:0] cur_txn = '0;
    always @(negedge sys_clk) begin
        if (!rst_a) begin
            if (a_if.write && !wr_prev) begin
                chk("done_low_at_write_rise", a_if.done, 0);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got %0h expected none", {a_if.register, a_if.data});
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (exp_q.size() == 0) tail_vol = 1'b0;
                    chk("txn", {a_if.register, a_if.data}, e);
                end
                cur_txn = {a_if.register, a_if.data};
            end else if (a_if.write) begin
                chk("stable_while_write", {a_if.register, a_if.data}, cur_txn);
            end
            if (ack_prev) chk("ack_one_cycle", a_if.vol_ack, 0);
            if (a_if.vol_ack) ack_seen++;
        end
        wr_prev = a_if.write;
        ack_prev = a_if.vol_ack;
    end

    task automatic wait_settled(input string name);
        int n;
        bit ok;
        n = 0; ok = 1'b0;
        while (n < 4000 && !ok) begin
            @(negedge sys_clk); n++;
            ok = a_if.ready && (ack_seen == ack_exp) && (exp_q.size() == 0);
        end
        chk({name, "_settle"}, ok, 1);
    endtask

    task automatic pulse_start();
        a_if.start = 1'b1; @(negedge sys_clk); a_if.start = 1'b0;
    endtask

    task automatic pulse_vol(input logic [6:0] v);
        a_if.vol_req = 1'b1; a_if.vol_level = v;
        @(negedge sys_clk);
        a_if.vol_req = 1'b0;
    endtask

    task automatic wait_step(input logic [2:0] s);
        int n;
        n = 0;
        while (n < 2000 && !(a_if.busy && a_if.step == s)) begin @(negedge sys_clk); n++; end
        chk("wait_step", (n < 2000), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [6:0] v;
        a_if.start = 1'b0; a_if.vol_req = 1'b0; a_if.vol_level = '0;
        b_if.start = 1'b0; b_if.vol_req = 1'b0; b_if.vol_level = '0; b_if.done = 1'b0;

        repeat (3) @(negedge sys_clk);
        chk("rst_outputs", {a_if.write, a_if.register, a_if.data, a_if.vol_ack,
                            a_if.busy, a_if.ready, a_if.error, a_if.step}, 0);
        push_table();
        rst_a = 1'b0;

        wait_settled("autostart");
        chk("ready_after_table", {a_if.ready, a_if.busy, a_if.error}, 3'b100);

        model_vol(7'h79);
        pulse_vol(7'h79);
        wait_settled("vol_in_ready");
        chk("ack_count_ready", ack_seen, ack_exp);

        push_table();
        pulse_start();
        wait_step(3'd2);
        model_vol(7'h30); pulse_vol(7'h30);
        wait_step(3'd4);
        model_vol(7'h50); pulse_vol(7'h50);
        wait_settled("vol_during_table");
        chk("ack_count_table", ack_seen, ack_exp);

        for (int r = 0; r < 3; r++) begin
            push_table();
            pulse_start();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                repeat ($urandom_range(5, 80)) @(negedge sys_clk);
                if (a_if.busy && a_if.step >= 3'd1 && a_if.step <= 3'd5) begin
                    v = 7'($urandom);
                    model_vol(v);
                    pulse_vol(v);
                end
            end
            wait_settled("random_round");
            chk("ack_count_random", ack_seen, ack_exp);
        end

        stall = 1'b1;
        exp_q.push_back(16'h1E00); tail_vol = 1'b0;
        pulse_start();
        n = 0;
        while (n < 50 && !a_if.write) begin @(negedge sys_clk); n++; end
        chk("timeout_write_rise", a_if.write, 1);
        n = 1;
        while (n < 1000) begin
            @(negedge sys_clk);
            if (a_if.write) n++; else break;
        end
        chk("timeout_write_cycles", n, 100);
        chk("timeout_status", {a_if.error, a_if.busy, a_if.ready}, 3'b100);
        stall = 1'b0;
        push_table();
        pulse_start();
        wait_settled("after_error");
        chk("ready_after_error", {a_if.ready, a_if.error}, 2'b10);

        push_table();
        pulse_start();
        n = 0;
        while (n < 2000 && !(a_if.write && a_if.step == 3'd3 && a_if.done)) begin
            @(negedge sys_clk); n++;
        end
        chk("reach_step3_done", (n < 2000), 1);
        rst_a = 1'b1; hold_hi = 1'b1;
        @(negedge sys_clk);
        chk("rst_mid_txn", {a_if.write, a_if.step, a_if.busy}, 0);
        exp_q.delete(); tail_vol = 1'b0;
        push_table();
        rst_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            chk("write_low_while_done_high", a_if.write, 0);
        end
        hold_hi = 1'b0;
        wait_settled("after_reset");

        @(negedge sys_clk);
        rst_b = 1'b0;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge sys_clk);
            if (b_if.write) n++;
        end
        chk("noauto_write_cycles", n, 0);
        b_if.start = 1'b1; @(negedge sys_clk); b_if.start = 1'b0;
        chk("noauto_write_after1", b_if.write, 0);
        @(negedge sys_clk);
        chk("noauto_write_after2", b_if.write, 1);
        chk("noauto_register", b_if.register, 8'h1E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
